// File: rtl/systolic_pkg.sv
// Shared types and helpers for the systolic GEMM tile engine.
package systolic_pkg;

  // Tile sequencing states.
  typedef enum logic [1:0] {
    S_LOAD  = 2'd0,
    S_FLUSH = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  localparam int unsigned SAT_W = 64;

  // Clamp an acc_w-bit signed value (sign-extended into SAT_W bits) to the out_w-bit signed range.
  // Returns {clamped_flag, clamped value sign-extended to SAT_W bits}.
  function automatic logic [SAT_W:0] sat_trunc(input logic [SAT_W-1:0] acc,
                                               input int unsigned acc_w,
                                               input int unsigned out_w);
    logic signed [SAT_W-1:0] sx;
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    sx = $signed(acc << (SAT_W - acc_w)) >>> (SAT_W - acc_w);
    hi = (64'sd1 <<< (out_w - 32'd1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (sx > hi)      return {1'b1, hi};
    else if (sx < lo) return {1'b1, lo};
    else              return {1'b0, sx};
  endfunction

endpackage

// File: rtl/systolic_pe_acc.sv
// One processing element: forwards operands right/down and accumulates their product.
module systolic_pe_acc #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ACC_WIDTH  = 24
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clr,
  input  logic signed [DATA_WIDTH-1:0] a_in,
  input  logic signed [DATA_WIDTH-1:0] b_in,
  output logic signed [DATA_WIDTH-1:0] a_out,
  output logic signed [DATA_WIDTH-1:0] b_out,
  output logic signed [ACC_WIDTH-1:0]  acc
);

  logic signed [2*DATA_WIDTH-1:0] prod;

  assign prod = a_in * b_in;

  // Operand pass registers and wrapping multiply-accumulate.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_out <= '0;
      b_out <= '0;
      acc   <= '0;
    end else begin
      a_out <= a_in;
      b_out <= b_in;
      if (clr) acc <= '0;
      else     acc <= acc + ACC_WIDTH'(prod);
    end
  end

endmodule

// File: rtl/systolic_mm_stream.sv
// Output-stationary systolic GEMM tile engine: streams K beats in, flushes, drains C row by row.
module systolic_mm_stream
  import systolic_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ACC_WIDTH  = 24,
  parameter int unsigned OUT_WIDTH  = 16,
  parameter int unsigned ROWS       = 4,
  parameter int unsigned COLS       = 4,
  parameter int unsigned SATURATE   = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [ROWS*DATA_WIDTH-1:0]    in_a,
  input  logic [COLS*DATA_WIDTH-1:0]    in_b,
  input  logic                          in_last,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [COLS*OUT_WIDTH-1:0]     out_data,
  output logic [$clog2(ROWS)-1:0]       out_row,
  output logic                          out_last,
  output logic                          out_sat,
  output logic                          busy
);

  localparam int unsigned RW    = $clog2(ROWS);
  localparam int unsigned CNT_W = $clog2(ROWS + COLS);

  state_t                        state;
  logic [CNT_W-1:0]              cnt;
  logic                          beat_seen;
  logic                          hs;
  logic                          clr;
  logic [RW-1:0]                 sel_row;
  logic [COLS*OUT_WIDTH-1:0]     nxt_data;
  logic [COLS-1:0]               col_sat;
  logic                          nxt_sat;
  logic [OUT_WIDTH-1:0]          col_val [COLS];

  logic signed [DATA_WIDTH-1:0]  a_h   [ROWS][COLS+1];
  logic signed [DATA_WIDTH-1:0]  b_v   [ROWS+1][COLS];
  logic signed [ACC_WIDTH-1:0]   acc_m [ROWS][COLS];

  assign in_ready = (state == S_LOAD) && !rst;
  assign hs       = in_valid && in_ready;
  assign busy     = (state != S_LOAD) || beat_seen;
  assign clr      = (state == S_DRAIN) && out_valid && out_ready && out_last;
  assign sel_row  = out_valid ? out_row + RW'(1) : '0;

  // A skew: row r sees the accepted beat r cycles later; idle cycles inject zeros.
  for (genvar r = 0; r < ROWS; r++) begin : g_askew
    logic signed [DATA_WIDTH-1:0] sk [r+1];
    always_ff @(posedge clk) begin
      if (rst) begin
        for (int d = 0; d <= r; d++) sk[d] <= '0;
      end else begin
        sk[0] <= hs ? $signed(in_a[r*DATA_WIDTH +: DATA_WIDTH]) : '0;
        for (int d = 1; d <= r; d++) sk[d] <= sk[d-1];
      end
    end
    assign a_h[r][0] = sk[r];
  end

  // B skew: column c sees the accepted beat c cycles later; idle cycles inject zeros.
  for (genvar c = 0; c < COLS; c++) begin : g_bskew
    logic signed [DATA_WIDTH-1:0] sk [c+1];
    always_ff @(posedge clk) begin
      if (rst) begin
        for (int d = 0; d <= c; d++) sk[d] <= '0;
      end else begin
        sk[0] <= hs ? $signed(in_b[c*DATA_WIDTH +: DATA_WIDTH]) : '0;
        for (int d = 1; d <= c; d++) sk[d] <= sk[d-1];
      end
    end
    assign b_v[0][c] = sk[c];
  end

  // PE grid: operands flow right (A) and down (B).
  for (genvar r = 0; r < ROWS; r++) begin : g_row
    for (genvar c = 0; c < COLS; c++) begin : g_pe
      systolic_pe_acc #(
        .DATA_WIDTH (DATA_WIDTH),
        .ACC_WIDTH  (ACC_WIDTH)
      ) u_pe (
        .clk   (clk),
        .rst   (rst),
        .clr   (clr),
        .a_in  (a_h[r][c]),
        .b_in  (b_v[r][c]),
        .a_out (a_h[r][c+1]),
        .b_out (b_v[r+1][c]),
        .acc   (acc_m[r][c])
      );
    end
  end

  // Per-column result mapping of the row about to be presented.
  for (genvar c = 0; c < COLS; c++) begin : g_col
    logic signed [ACC_WIDTH-1:0] a_sel;
    assign a_sel = acc_m[sel_row][c];
    if (SATURATE != 0) begin : g_sat
      logic [SAT_W:0] res;
      logic           res_unused;
      assign res        = sat_trunc(SAT_W'(a_sel), ACC_WIDTH, OUT_WIDTH);
      assign res_unused = ^res[SAT_W-1:OUT_WIDTH];
      assign col_val[c] = res[OUT_WIDTH-1:0];
      assign col_sat[c] = res[SAT_W];
    end else begin : g_trunc
      assign col_val[c] = a_sel[OUT_WIDTH-1:0];
      assign col_sat[c] = 1'b0;
      if (ACC_WIDTH > OUT_WIDTH) begin : g_hi
        logic hi_unused;
        assign hi_unused = ^a_sel[ACC_WIDTH-1:OUT_WIDTH];
      end
    end
  end

  // Pack mapped columns into the next output row.
  always_comb begin
    nxt_data = '0;
    for (int c = 0; c < COLS; c++) nxt_data[c*OUT_WIDTH +: OUT_WIDTH] = col_val[c];
    nxt_sat = |col_sat;
  end

  // Tile sequencer with registered output row.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_LOAD;
      cnt       <= '0;
      beat_seen <= 1'b0;
      out_valid <= 1'b0;
      out_row   <= '0;
      out_last  <= 1'b0;
      out_sat   <= 1'b0;
      out_data  <= '0;
    end else begin
      case (state)
        S_LOAD: begin
          if (hs) begin
            beat_seen <= 1'b1;
            if (in_last) begin
              state <= S_FLUSH;
              cnt   <= '0;
            end
          end
        end
        S_FLUSH: begin
          if (cnt == CNT_W'(ROWS + COLS - 2)) state <= S_DRAIN;
          else                                cnt   <= cnt + CNT_W'(1);
        end
        S_DRAIN: begin
          if (!out_valid) begin
            out_valid <= 1'b1;
            out_row   <= '0;
            out_last  <= 1'b0;
            out_data  <= nxt_data;
            out_sat   <= nxt_sat;
          end else if (out_ready) begin
            if (out_last) begin
              state     <= S_LOAD;
              beat_seen <= 1'b0;
              out_valid <= 1'b0;
              out_row   <= '0;
              out_last  <= 1'b0;
              out_sat   <= 1'b0;
            end else begin
              out_row  <= out_row + RW'(1);
              out_last <= (out_row == RW'(ROWS - 2));
              out_data <= nxt_data;
              out_sat  <= nxt_sat;
            end
          end
        end
        default: state <= S_LOAD;
      endcase
    end
  end

endmodule
